csr_exec_pipe: RTL

- Parametrised CSR execute stage; successor to the single-width CSR handler.
- Decodes CSRRW/RS/RC/RWI/RSI/RCI from funct3 and computes old and new CSR values.
- Forwards uncommitted CSR results from a FWD_DEPTH-entry in-flight table, with valid/ready handshakes on both sides.
- Sits between decode/issue and write-back; the CSR file is written only when write-back commits.

---
 rtl/csr_exec_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/csr_exec_pipe.sv
// CSR execute stage: decodes Zicsr ops, forwards uncommitted CSR writes from an
// in-flight table and registers {addr, old, new, wen, illegal} for write-back.
module csr_exec_pipe #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 12,
  parameter int FWD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [4:0]        in_src_idx,
  output logic [ADDR_W-1:0] file_raddr,
  input  logic [XLEN-1:0]   file_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [XLEN-1:0]   out_old,
  output logic [XLEN-1:0]   out_new,
  output logic              out_wen,
  output logic              out_illegal,
  input  logic              wb_commit,
  output logic              commit_err
);

  localparam int PTR_W = (FWD_DEPTH > 1) ? $clog2(FWD_DEPTH) : 1;
  localparam int CNT_W = $clog2(FWD_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FWD_DEPTH);

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_e;

  logic              r_out_valid, r_out_wen, r_out_ill, r_commit_err;
  logic [ADDR_W-1:0] r_out_addr;
  logic [XLEN-1:0]   r_out_old, r_out_new;

  logic [ADDR_W-1:0] r_tbl_addr [FWD_DEPTH];
  logic [XLEN-1:0]   r_tbl_data [FWD_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full, w_tbl_block, w_accept, w_out_fire, w_push, w_pop, w_commit_err;
  logic              w_tbl_hit, w_wen, w_ill;
  logic [XLEN-1:0]   w_tbl_val, w_old, w_new, w_operand;
  csr_op_e           w_op;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FWD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A result that must enter a full table waits in the output register until a commit frees a slot.
  assign w_full       = (r_count == FULL_CNT);
  assign w_tbl_block  = w_full & r_out_valid & r_out_wen & ~wb_commit;
  assign in_ready     = (~r_out_valid | out_ready) & ~w_tbl_block;
  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_out_fire   = r_out_valid & out_ready & ~w_tbl_block;
  assign w_push       = w_out_fire & r_out_wen;
  assign w_pop        = wb_commit & ((r_count != '0) | w_push);
  assign w_commit_err = wb_commit & (r_count == '0) & ~w_push;

  assign file_raddr = in_addr;

  // Oldest-to-newest scan so the newest matching entry wins.
  always_comb begin
    int idx;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_tbl_hit = 1'b0;
    w_tbl_val = '0;
    idx       = 0;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      idx = int'(r_rd_ptr) + i;
      if (idx >= FWD_DEPTH) idx = idx - FWD_DEPTH;
      if ((CNT_W'(i) < r_count) && (r_tbl_addr[PTR_W'(idx)] == in_addr)) begin
        w_tbl_hit = 1'b1;
        w_tbl_val = r_tbl_data[PTR_W'(idx)];
      end
    end
  end

  always_comb begin
    w_op      = csr_op_e'(in_funct3[1:0]);
    w_operand = in_funct3[2] ? XLEN'(in_src_idx) : in_rs1_val;
    if (r_out_valid && r_out_wen && (r_out_addr == in_addr)) w_old = r_out_new;
    else if (w_tbl_hit)                                      w_old = w_tbl_val;
    else                                                     w_old = file_rdata;
    w_new = '0;
    w_wen = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      OP_RW: begin
        w_new = w_operand;
        w_wen = 1'b1;
      end
      OP_RS: begin
        w_new = w_old | w_operand;
        w_wen = (in_src_idx != 5'd0);
      end
      OP_RC: begin
        w_new = w_old & ~w_operand;
        w_wen = (in_src_idx != 5'd0);
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_wen    <= 1'b0;
      r_out_ill    <= 1'b0;
      r_out_addr   <= '0;
      r_out_old    <= '0;
      r_out_new    <= '0;
      r_commit_err <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      if (w_commit_err && !flush) r_commit_err <= 1'b1;
      if (flush) begin
        r_out_valid <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_addr  <= in_addr;
          r_out_old   <= w_old;
          r_out_new   <= w_new;
          r_out_wen   <= w_wen;
          r_out_ill   <= w_ill;
        end else if (w_out_fire) begin
          r_out_valid <= 1'b0;
        end
        if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // NOTE: table storage has no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_tbl_addr[r_wr_ptr] <= r_out_addr;
      r_tbl_data[r_wr_ptr] <= r_out_new;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_addr    = r_out_addr;
  assign out_old     = r_out_old;
  assign out_new     = r_out_new;
  assign out_wen     = r_out_wen;
  assign out_illegal = r_out_ill;
  assign commit_err  = r_commit_err;

endmodule
